// File: rtl/button_events_pkg.sv
// Shared constants for the four-button event decoder: state encoding,
// default timing and small helpers used by the top level and per-button FSMs.
package button_events_pkg;

   localparam int unsigned NUM_BTN           = 4;
   localparam int unsigned DEF_LONG_CYCLES   = 50_000_000;
   localparam int unsigned DEF_REPEAT_CYCLES = 10_000_000;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_PRESSED = 2'd1;
   localparam logic [1:0] ST_LONG    = 2'd2;

   // Hold counter only has to reach the larger terminal count minus one.
   function automatic int unsigned cnt_width(input int unsigned long_c,
                                             input int unsigned repeat_c);
      int unsigned m;
      m = (long_c > repeat_c) ? long_c : repeat_c;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

   function automatic logic [1:0] lowest_index(input logic [NUM_BTN-1:0] v);
      logic [1:0] idx;
      idx = '0;
      for (int i = NUM_BTN - 1; i >= 0; i--) begin
         if (v[i]) idx = 2'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/button_events_if.sv
// Button-level bundle: debounced levels in, per-button event pulses and
// key-code report out. The producer of fb uses master, the decoder slave.
interface button_events_if;
   import button_events_pkg::*;

   logic [NUM_BTN-1:0] fb;
   logic [NUM_BTN-1:0] press;
   logic [NUM_BTN-1:0] release_ev;
   logic [NUM_BTN-1:0] long_press;
   logic [NUM_BTN-1:0] repeat_ev;
   logic [NUM_BTN-1:0] held;
   logic [1:0]         key_code;
   logic               key_valid;

   modport master (
      output fb,
      input  press, release_ev, long_press, repeat_ev, held, key_code, key_valid
   );

   modport slave (
      input  fb,
      output press, release_ev, long_press, repeat_ev, held, key_code, key_valid
   );

endinterface

// File: rtl/button_fsm.sv
// One button: IDLE/PRESSED/LONG state machine with a shared hold counter that
// times the long-press and then the auto-repeat interval.
module button_fsm
   import button_events_pkg::*;
#(
   parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES,
   parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
   input  logic clock,
   input  logic reset_n,
   input  logic pressed,
   output logic press,
   output logic release_ev,
   output logic long_press,
   output logic repeat_ev,
   output logic held
);

   localparam int unsigned    CW      = cnt_width(LONG_CYCLES, REPEAT_CYCLES);
   localparam logic [CW-1:0]  LONG_TC = CW'(LONG_CYCLES - 1);
   localparam logic [CW-1:0]  REP_TC  = CW'(REPEAT_CYCLES - 1);

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          press_q, press_d;
   logic          release_q, release_d;
   logic          long_q, long_d;
   logic          repeat_q, repeat_d;
   logic          held_q;

   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // leaves a value unassigned, which would infer a latch.
      state_d   = state_q;
      cnt_d     = cnt_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      long_d    = 1'b0;
      repeat_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (pressed) begin
               state_d = ST_PRESSED;
               press_d = 1'b1;
               cnt_d   = '0;
            end
         end
         ST_PRESSED: begin
            // Release is tested first so it wins over a coincident terminal count.
            if (!pressed) begin
               state_d   = ST_IDLE;
               release_d = 1'b1;
               cnt_d     = '0;
            end else if (cnt_q == LONG_TC) begin
               state_d = ST_LONG;
               long_d  = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_LONG: begin
            if (!pressed) begin
               state_d   = ST_IDLE;
               release_d = 1'b1;
               cnt_d     = '0;
            end else if (cnt_q == REP_TC) begin
               repeat_d = 1'b1;
               cnt_d    = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         long_q    <= 1'b0;
         repeat_q  <= 1'b0;
         held_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments here so all state updates see the
         // pre-edge values regardless of statement order.
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         press_q   <= press_d;
         release_q <= release_d;
         long_q    <= long_d;
         repeat_q  <= repeat_d;
         held_q    <= (state_d != ST_IDLE);
      end
   end

   assign press      = press_q;
   assign release_ev = release_q;
   assign long_press = long_q;
   assign repeat_ev  = repeat_q;
   assign held       = held_q;

endmodule

// File: rtl/button_events.sv
// Four-button event decoder: registers the debounced levels once, runs one
// independent FSM per button and reports the most recently pressed key.
module button_events
   import button_events_pkg::*;
#(
   parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES,
   parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES,
   parameter bit          ACTIVE_LOW    = 1'b1
) (
   input  logic            clock,
   input  logic            reset_n,
   button_events_if.slave  bus
);

   logic [NUM_BTN-1:0] pressed_q;
   logic [NUM_BTN-1:0] press_w, release_w, long_w, repeat_w, held_w;
   logic [NUM_BTN-1:0] press_evt;
   logic [1:0]         key_code_q;
   logic               key_valid_q;

   // Reset value 0 means "not pressed" whatever the input polarity, so a key
   // already down at reset release still produces a press event.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) pressed_q <= '0;
      else          pressed_q <= bus.fb ^ {NUM_BTN{ACTIVE_LOW}};
   end

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
      button_fsm #(
         .LONG_CYCLES   (LONG_CYCLES),
         .REPEAT_CYCLES (REPEAT_CYCLES)
      ) u_fsm (
         .clock      (clock),
         .reset_n    (reset_n),
         .pressed    (pressed_q[i]),
         .press      (press_w[i]),
         .release_ev (release_w[i]),
         .long_press (long_w[i]),
         .repeat_ev  (repeat_w[i]),
         .held       (held_w[i])
      );
   end

   // An FSM leaves IDLE exactly when it sees pressed while not yet held, so
   // this predicts the press pulses that the FSMs register on the same edge.
   assign press_evt = pressed_q & ~held_w;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         key_code_q  <= '0;
         key_valid_q <= 1'b0;
      end else begin
         key_valid_q <= |press_evt;
         if (|press_evt) key_code_q <= lowest_index(press_evt);
      end
   end

   assign bus.press      = press_w;
   assign bus.release_ev = release_w;
   assign bus.long_press = long_w;
   assign bus.repeat_ev  = repeat_w;
   assign bus.held       = held_w;
   assign bus.key_code   = key_code_q;
   assign bus.key_valid  = key_valid_q;

endmodule

// File: tb/tb_button_events.sv
// Scoreboard bench for button_events: an active-low build (8/4 cycle timing)
// and an active-high build share clock and reset; expected events are queued
// with their cycle number when stimulus is driven.
module tb_button_events;

   typedef struct {
      int         cyc;
      logic [3:0] press;
      logic [3:0] rel;
      logic [3:0] lp;
      logic [3:0] rp;
      logic       kv;
      logic [1:0] kc;
   } ev_t;

   logic clock;
   logic reset_n;
   int   cyc;
   int   checks;
   int   failures;
   ev_t  q_a[$];
   ev_t  q_b[$];
   ev_t  ea, eb;

   button_events_if if_a ();
   button_events_if if_b ();

   button_events #(.LONG_CYCLES(8), .REPEAT_CYCLES(4), .ACTIVE_LOW(1'b1)) dut_a (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (if_a)
   );

   button_events #(.LONG_CYCLES(8), .REPEAT_CYCLES(4), .ACTIVE_LOW(1'b0)) dut_b (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (if_b)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial cyc = 0;
   always @(posedge clock) cyc++;

   function automatic ev_t mk_ev(int c, logic [3:0] p, logic [3:0] r,
                                 logic [3:0] l, logic [3:0] rp, logic [1:0] kc);
      ev_t e;
      e.cyc = c; e.press = p; e.rel = r; e.lp = l; e.rp = rp;
      e.kv = |p; e.kc = kc;
      return e;
   endfunction

   // Scoreboard: every pulse seen must match the head of the queue at its cycle.
   always @(negedge clock) begin
      while (q_a.size() > 0 && q_a[0].cyc < cyc) begin
         ea = q_a.pop_front();
         checks++; failures++;
         $display("FAIL a_missing_event expected at cyc=%0d not seen (now %0d)", ea.cyc, cyc);
      end
      if (|{if_a.press, if_a.release_ev, if_a.long_press, if_a.repeat_ev, if_a.key_valid}) begin
         checks++;
         if (q_a.size() == 0) begin
            failures++;
            $display("FAIL a_unexpected_event cyc=%0d press=%b rel=%b long=%b rep=%b kv=%b",
                     cyc, if_a.press, if_a.release_ev, if_a.long_press, if_a.repeat_ev, if_a.key_valid);
         end else begin
            ea = q_a.pop_front();
            if (ea.cyc !== cyc || if_a.press !== ea.press || if_a.release_ev !== ea.rel ||
                if_a.long_press !== ea.lp || if_a.repeat_ev !== ea.rp || if_a.key_valid !== ea.kv ||
                (ea.kv && if_a.key_code !== ea.kc)) begin
               failures++;
               $display("FAIL a_event got cyc=%0d p=%b r=%b l=%b rp=%b kv=%b kc=%0d want cyc=%0d p=%b r=%b l=%b rp=%b kv=%b kc=%0d",
                        cyc, if_a.press, if_a.release_ev, if_a.long_press, if_a.repeat_ev, if_a.key_valid, if_a.key_code,
                        ea.cyc, ea.press, ea.rel, ea.lp, ea.rp, ea.kv, ea.kc);
            end
         end
      end
      while (q_b.size() > 0 && q_b[0].cyc < cyc) begin
         eb = q_b.pop_front();
         checks++; failures++;
         $display("FAIL b_missing_event expected at cyc=%0d not seen (now %0d)", eb.cyc, cyc);
      end
      if (|{if_b.press, if_b.release_ev, if_b.long_press, if_b.repeat_ev, if_b.key_valid}) begin
         checks++;
         if (q_b.size() == 0) begin
            failures++;
            $display("FAIL b_unexpected_event cyc=%0d press=%b rel=%b long=%b rep=%b kv=%b",
                     cyc, if_b.press, if_b.release_ev, if_b.long_press, if_b.repeat_ev, if_b.key_valid);
         end else begin
            eb = q_b.pop_front();
            if (eb.cyc !== cyc || if_b.press !== eb.press || if_b.release_ev !== eb.rel ||
                if_b.long_press !== eb.lp || if_b.repeat_ev !== eb.rp || if_b.key_valid !== eb.kv ||
                (eb.kv && if_b.key_code !== eb.kc)) begin
               failures++;
               $display("FAIL b_event got cyc=%0d p=%b r=%b l=%b rp=%b kv=%b kc=%0d want cyc=%0d p=%b r=%b l=%b rp=%b kv=%b kc=%0d",
                        cyc, if_b.press, if_b.release_ev, if_b.long_press, if_b.repeat_ev, if_b.key_valid, if_b.key_code,
                        eb.cyc, eb.press, eb.rel, eb.lp, eb.rp, eb.kv, eb.kc);
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic test_reset();
      reset_n  = 1'b0;
      if_a.fb  = 4'hF;
      if_b.fb  = 4'h0;
      step(3);
      checks++;
      if ({if_a.press, if_a.release_ev, if_a.long_press, if_a.repeat_ev, if_a.held,
           if_a.key_code, if_a.key_valid} !== 23'd0) begin
         failures++;
         $display("FAIL reset_a outputs got p=%b r=%b l=%b rp=%b h=%b kc=%0d kv=%b want all zero",
                  if_a.press, if_a.release_ev, if_a.long_press, if_a.repeat_ev, if_a.held, if_a.key_code, if_a.key_valid);
      end
      checks++;
      if ({if_b.press, if_b.release_ev, if_b.long_press, if_b.repeat_ev, if_b.held,
           if_b.key_code, if_b.key_valid} !== 23'd0) begin
         failures++;
         $display("FAIL reset_b outputs got p=%b h=%b kc=%0d want all zero", if_b.press, if_b.held, if_b.key_code);
      end
      reset_n = 1'b1;
      step(4);
      checks++;
      if (if_a.held !== 4'b0000 || if_b.held !== 4'b0000) begin
         failures++;
         $display("FAIL idle_after_reset held_a=%b held_b=%b want 0000", if_a.held, if_b.held);
      end
   endtask

   task automatic test_short_press();
      int t0;
      t0 = cyc;
      if_a.fb[0] = 1'b0;
      q_a.push_back(mk_ev(t0 + 2, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 2'd0));
      q_a.push_back(mk_ev(t0 + 5, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 2'd0));
      step(3);
      checks++;
      if (if_a.held !== 4'b0001) begin
         failures++; $display("FAIL short_held got %b want 0001", if_a.held);
      end
      if_a.fb[0] = 1'b1;
      step(3);
      checks++;
      if (if_a.held !== 4'b0000) begin
         failures++; $display("FAIL short_held_drop got %b want 0000", if_a.held);
      end
      step(10);
      checks++;
      if (q_a.size() != 0) begin
         failures++; $display("FAIL short_pending got %0d events left want 0", q_a.size());
      end
   endtask

   task automatic test_long_repeat();
      int t0;
      t0 = cyc;
      if_a.fb[1] = 1'b0;
      q_a.push_back(mk_ev(t0 + 2,  4'b0010, 4'b0000, 4'b0000, 4'b0000, 2'd1));
      q_a.push_back(mk_ev(t0 + 10, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 2'd0));
      q_a.push_back(mk_ev(t0 + 14, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 2'd0));
      q_a.push_back(mk_ev(t0 + 18, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 2'd0));
      q_a.push_back(mk_ev(t0 + 22, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 2'd0));
      step(12);
      checks++;
      if (if_a.held !== 4'b0010) begin
         failures++; $display("FAIL long_held got %b want 0010", if_a.held);
      end
      step(8);
      if_a.fb[1] = 1'b1;
      step(4);
      checks++;
      if (if_a.held !== 4'b0000) begin
         failures++; $display("FAIL long_held_drop got %b want 0000", if_a.held);
      end
      step(6);
      checks++;
      if (q_a.size() != 0) begin
         failures++; $display("FAIL long_pending got %0d events left want 0", q_a.size());
      end
   endtask

   task automatic test_simultaneous();
      int t0;
      t0 = cyc;
      if_a.fb[3:2] = 2'b00;
      q_a.push_back(mk_ev(t0 + 2, 4'b1100, 4'b0000, 4'b0000, 4'b0000, 2'd2));
      q_a.push_back(mk_ev(t0 + 6, 4'b0000, 4'b1100, 4'b0000, 4'b0000, 2'd0));
      step(3);
      checks++;
      if (if_a.key_code !== 2'd2 || if_a.held !== 4'b1100) begin
         failures++; $display("FAIL simul_state got kc=%0d held=%b want kc=2 held=1100", if_a.key_code, if_a.held);
      end
      step(1);
      if_a.fb[3:2] = 2'b11;
      step(4);
      checks++;
      if (if_a.key_code !== 2'd2) begin
         failures++; $display("FAIL key_code_hold got %0d want 2", if_a.key_code);
      end
      step(4);
      checks++;
      if (q_a.size() != 0) begin
         failures++; $display("FAIL simul_pending got %0d events left want 0", q_a.size());
      end
   endtask

   task automatic test_release_on_terminal();
      int t0;
      t0 = cyc;
      if_a.fb[0] = 1'b0;
      q_a.push_back(mk_ev(t0 + 2,  4'b0001, 4'b0000, 4'b0000, 4'b0000, 2'd0));
      q_a.push_back(mk_ev(t0 + 10, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 2'd0));
      step(8);
      if_a.fb[0] = 1'b1;
      step(4);
      checks++;
      if (if_a.held !== 4'b0000) begin
         failures++; $display("FAIL terminal_held got %b want 0000", if_a.held);
      end
      step(6);
      checks++;
      if (q_a.size() != 0) begin
         failures++; $display("FAIL terminal_pending got %0d events left want 0", q_a.size());
      end
   endtask

   task automatic test_back_to_back();
      int t0;
      t0 = cyc;
      if_a.fb[0] = 1'b0;
      q_a.push_back(mk_ev(t0 + 2, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 2'd0));
      step(1);
      if_a.fb[3] = 1'b0;
      q_a.push_back(mk_ev(t0 + 3, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 2'd3));
      step(2);
      checks++;
      if (if_a.held !== 4'b1001 || if_a.key_code !== 2'd3) begin
         failures++; $display("FAIL b2b_state got held=%b kc=%0d want held=1001 kc=3", if_a.held, if_a.key_code);
      end
      if_a.fb[0] = 1'b1;
      if_a.fb[3] = 1'b1;
      q_a.push_back(mk_ev(t0 + 5, 4'b0000, 4'b1001, 4'b0000, 4'b0000, 2'd0));
      step(8);
      checks++;
      if (q_a.size() != 0) begin
         failures++; $display("FAIL b2b_pending got %0d events left want 0", q_a.size());
      end
   endtask

   task automatic test_reset_mid_hold();
      int t0;
      int r;
      t0 = cyc;
      if_a.fb[1] = 1'b0;
      q_a.push_back(mk_ev(t0 + 2,  4'b0010, 4'b0000, 4'b0000, 4'b0000, 2'd1));
      q_a.push_back(mk_ev(t0 + 10, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 2'd0));
      step(12);
      checks++;
      if (if_a.held !== 4'b0010 || if_a.key_code !== 2'd1) begin
         failures++; $display("FAIL pre_reset got held=%b kc=%0d want held=0010 kc=1", if_a.held, if_a.key_code);
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if ({if_a.press, if_a.release_ev, if_a.long_press, if_a.repeat_ev, if_a.held,
           if_a.key_code, if_a.key_valid} !== 23'd0) begin
         failures++;
         $display("FAIL mid_reset outputs got h=%b kc=%0d p=%b r=%b want all zero",
                  if_a.held, if_a.key_code, if_a.press, if_a.release_ev);
      end
      step(2);
      reset_n = 1'b1;
      r = cyc;
      q_a.push_back(mk_ev(r + 2, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 2'd1));
      q_a.push_back(mk_ev(r + 6, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 2'd0));
      step(3);
      checks++;
      if (if_a.held !== 4'b0010) begin
         failures++; $display("FAIL post_reset_held got %b want 0010", if_a.held);
      end
      step(1);
      if_a.fb[1] = 1'b1;
      step(6);
      checks++;
      if (q_a.size() != 0 || if_a.held !== 4'b0000) begin
         failures++; $display("FAIL post_reset_pending got %0d events held=%b want 0 events held=0000", q_a.size(), if_a.held);
      end
   endtask

   task automatic test_active_high();
      int t0;
      t0 = cyc;
      if_b.fb[0] = 1'b1;
      q_b.push_back(mk_ev(t0 + 2, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 2'd0));
      q_b.push_back(mk_ev(t0 + 5, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 2'd0));
      step(3);
      checks++;
      if (if_b.held !== 4'b0001) begin
         failures++; $display("FAIL ah_held got %b want 0001", if_b.held);
      end
      if_b.fb[0] = 1'b0;
      step(10);
      checks++;
      if (q_b.size() != 0 || if_b.held !== 4'b0000) begin
         failures++; $display("FAIL ah_pending got %0d events held=%b want 0 events held=0000", q_b.size(), if_b.held);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_short_press();
      test_long_repeat();
      test_simultaneous();
      test_release_on_terminal();
      test_back_to_back();
      test_reset_mid_hold();
      test_active_high();
      step(2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
